// File: rtl/fp64_row_feeder.sv
// rtl/fp64_row_feeder.sv - serializes the kept fp64 lanes of each row into the accumulator
// and forwards the returned row sum tagged with a wrapping row index.
module fp64_row_feeder #(
  parameter int LANES = 8,
  parameter int IDX_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [64*LANES-1:0]   s_tdata,
  input  logic [LANES-1:0]      s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [63:0]           m_fp64_tdata,
  output logic                  m_fp64_tvalid,
  input  logic                  m_fp64_tready,
  output logic                  clr_valid,
  input  logic                  clr_ready,
  input  logic [63:0]           s_sum_tdata,
  input  logic                  s_sum_tvalid,
  output logic                  s_sum_tready,
  output logic [63:0]           m_sum_tdata,
  output logic [IDX_W-1:0]      m_sum_tuser,
  output logic                  m_sum_tvalid,
  input  logic                  m_sum_tready
);

  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [63:0] NEG_ZERO = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT_SUM, EMIT} state_t;
  state_t state, state_nxt;

  logic [64*LANES-1:0] buf_data;
  logic [LANES-1:0]    buf_keep;
  logic                buf_last;
  logic                buf_valid;
  logic                elem_seen;
  logic [63:0]         sum_q;
  logic [IDX_W-1:0]    row_idx;

  logic [SEL_W-1:0]    lane_sel;
  logic [63:0]         lane_data;
  logic [LANES-1:0]    lane_onehot;
  logic                in_fire;
  logic                elem_fire;
  logic                beat_retire;

  // Lowest remaining kept lane wins, so lanes leave in ascending order.
  always_comb begin
    lane_sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (buf_keep[i]) lane_sel = SEL_W'(i);
    end
  end

  assign lane_data   = buf_data[64*lane_sel +: 64];
  assign lane_onehot = buf_keep & (~buf_keep + LANES'(1));

  assign s_tready      = (state == FEED) && !buf_valid;
  assign in_fire       = s_tvalid && s_tready;
  assign m_fp64_tvalid = buf_valid && (|buf_keep);
  assign elem_fire     = m_fp64_tvalid && m_fp64_tready;
  // The beat leaves the buffer on the same edge as its last element, or one
  // cycle after capture when nothing in it was kept.
  assign beat_retire   = buf_valid && ((buf_keep == '0) ||
                                       (elem_fire && (buf_keep == lane_onehot)));
  assign m_fp64_tdata  = (!m_fp64_tvalid || lane_data == NEG_ZERO) ? 64'd0 : lane_data;

  assign clr_valid    = (state == CLEAR);
  assign s_sum_tready = (state == WAIT_SUM);
  assign m_sum_tvalid = (state == EMIT);
  assign m_sum_tdata  = sum_q;
  assign m_sum_tuser  = row_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (s_tvalid) state_nxt = CLEAR;
      CLEAR:    if (clr_ready) state_nxt = FEED;
      FEED: begin
        if (beat_retire && buf_last) state_nxt = (elem_seen || elem_fire) ? WAIT_SUM : EMIT;
      end
      WAIT_SUM: if (s_sum_tvalid) state_nxt = EMIT;
      EMIT:     if (m_sum_tready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_data  <= '0;
      buf_keep  <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
      elem_seen <= 1'b0;
      sum_q     <= '0;
      row_idx   <= '0;
    end else begin
      state <= state_nxt;

      if (state == CLEAR) elem_seen <= 1'b0;
      else if (elem_fire) elem_seen <= 1'b1;

      if (in_fire) begin
        buf_valid <= 1'b1;
        buf_data  <= s_tdata;
        buf_keep  <= s_tkeep;
        buf_last  <= s_tlast;
      end else begin
        if (elem_fire) buf_keep <= buf_keep & ~lane_onehot;
        if (beat_retire) buf_valid <= 1'b0;
      end

      // A row that never sent an element reports zero without asking the accumulator.
      if (state == FEED && state_nxt == EMIT) sum_q <= '0;
      else if (state == WAIT_SUM && s_sum_tvalid) sum_q <= s_sum_tdata;

      if (state == EMIT && m_sum_tready) row_idx <= row_idx + IDX_W'(1);
    end
  end

endmodule

// File: doc/fp64_row_feeder.md
# fp64_row_feeder

Producer-side companion to the fixed-point fp64 accumulator. Takes wide AXI-stream beats of packed fp64 values (one row = beats up to and including `tlast`) and serializes the kept lanes onto the accumulator's 64-bit fp64 input stream. It issues one accumulator clear handshake before each row, collects that row's sum, and forwards the sum tagged with a row index. Sits between the 512-bit datapath and the accumulator inside the 250 MHz box; one row is in flight at a time.

## Interface
- `LANES`, 8: fp64 lanes per input beat.
- `IDX_W`, 16: width of the row index tag.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_tdata`  in  64*LANES  lane i = bits [64i+:64].
- `s_tkeep`  in  LANES  per-lane valid mask; any pattern is allowed.
- `s_tlast`  in  1  last beat of a row.
- `s_tvalid` / `s_tready`  in / out  1  input handshake.
- `m_fp64_tdata`  out  64  element to the accumulator.
- `m_fp64_tvalid` / `m_fp64_tready`  out / in  1  element handshake.
- `clr_valid` / `clr_ready`  out / in  1  accumulator clear handshake.
- `s_sum_tdata`  in  64  fp64 sum returned by the accumulator.
- `s_sum_tvalid` / `s_sum_tready`  in / out  1  sum handshake.
- `m_sum_tdata`  out  64  row sum.
- `m_sum_tuser`  out  IDX_W  row index.
- `m_sum_tvalid` / `m_sum_tready`  out / in  1  result handshake.

## Operation
- **FSM states:** IDLE, CLEAR, FEED, WAIT_SUM, EMIT.
- **IDLE:** on `s_tvalid`=1, go to CLEAR. No input beat is consumed in IDLE.
- **CLEAR:** `clr_valid`=1. When `clr_valid`&&`clr_ready`, go to FEED.
- **FEED, beat capture:**
  - `s_tready` = (state==FEED) && !buf_valid.
  - On the handshake, capture data, keep and last into the beat buffer and clear `elem_seen` on the first beat of the row.
- **FEED, lane serialization:**
  - `m_fp64_tvalid` = buf_valid && (a remaining kept lane exists).
  - `m_fp64_tdata` = the lowest-index remaining kept lane, sent in ascending order.
  - Each element handshake retires that lane and sets `elem_seen`.
- **FEED, beat retire:**
  - When no kept lanes remain, buf_valid drops.
  - If buf_last, go to WAIT_SUM when `elem_seen`=1, else go to EMIT with sum=0.
  - A beat with `tkeep`=0 retires the cycle after capture and emits nothing.
- **Negative zero:** `0x8000_0000_0000_0000` is emitted as `0x0`, because the accumulator treats only all-zero data as zero. All other values pass bit-exact.
- **WAIT_SUM:** `s_sum_tready`=1. On the sum handshake, latch the sum and go to EMIT. `s_sum_tready`=0 in every other state, so early sums are stalled, not dropped.
- **EMIT:**
  - `m_sum_tvalid`=1 with the latched sum and `m_sum_tuser`=row_idx, both held stable until `m_sum_tready`.
  - On the handshake, row_idx increments (wrapping 2^IDX_W−1 → 0) and the FSM returns to IDLE.
- **Empty row** (all beats `tkeep`=0): a clear is still issued, no elements are sent, and the emitted sum is `0x0` without any sum handshake.

## Timing
- **Reset values:** state=IDLE, buf_valid=0, row_idx=0. All outputs are 0, including `s_tready`, `m_fp64_tvalid`, `clr_valid`, `s_sum_tready` and `m_sum_tvalid`.
- **Reset mid-row:** the buffered beat and latched sum are discarded and row_idx returns to 0. Leftover accumulator state is cleared by the next row's CLEAR.
- **Registered outputs:** `clr_valid`, `m_sum_*` and the beat buffer are registered.
- **Combinational outputs:** `m_fp64_*` are combinational from the buffer, using a priority find of the next kept lane.
- **Row-start latency:** `s_tvalid` rising in IDLE gives `clr_valid`=1 on the next cycle. With `clr_ready`=1 the first `s_tready` follows one cycle later.
- **Throughput:** a beat with k kept lanes occupies k+1 cycles (1 capture + k element cycles) under no backpressure, with no idle cycles between its lanes.
- **Result latency:** `m_sum_tvalid` rises the cycle after the sum handshake, or the cycle after the retiring of an empty last beat.
- **AXI rule:** once asserted, every valid output holds its value and stays asserted until its handshake completes.

## Test plan
1. **Single full row:** one beat, `tkeep`=0xFF, 8×`0x3FF0000000000000`, `tlast`=1; the accumulator model returns `0x4020000000000000`. Required: exactly one clear handshake, then 8 consecutive element handshakes, then `m_sum_tdata`=`0x4020000000000000` with `m_sum_tuser`=0.
2. **Backpressure:** 3-beat row (lanes = 1.0…24.0) with `m_fp64_tready` toggled pseudo-randomly and `m_sum_tready` held low for 10 cycles. Required: 24 elements in order with no duplicates or drops; the sum is held stable until accepted; no second clear occurs before the sum handshake.
3. **Sparse keep:** `tkeep`=0b10100101. Required: lanes 0, 2, 5, 7 only, in that order, on 4 consecutive cycles with ready=1.
4. **Negative zero and empty beat:** beat 1 = lane 0 `0x8000000000000000`, lane 1 `0xC000000000000000` (−2.0); beat 2 = `tkeep`=0 with `tlast`=1. Required: elements `0x0`, `0xC000000000000000`; the row ends after beat 2.
5. **Empty row and index wrap:** preload row_idx=0xFFFF via 65535 empty rows (or force), then send a row with `tkeep`=0, `tlast`=1. Required: one clear, no elements, `s_sum_tready` never 1, `m_sum_tdata`=0 with `m_sum_tuser`=0xFFFF; the next row is tagged 0.
6. **Reset mid-row:** assert `rst` for 1 cycle after the 3rd element of an 8-lane beat. Required: all outputs 0 the following cycle, state IDLE; the next row starts with a clear and is tagged 0.
